// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory: round-robin by default,
// fixed priority (port 0 wins ties) when DMEM_ARB_FIXED_PRIO_EN is defined.
module dmem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] RESP   = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pick1;
    logic              in_access;
    logic              in_resp;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pick1   = 1'b0;
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    pick1 = !r0_req;
`else
                    // On a tie the port that was not served last time wins.
                    pick1 = r1_req && (!r0_req || !last_q);
`endif
                    win_d   = pick1;
                    last_d  = pick1;
                    we_d    = pick1 ? r1_we    : r0_we;
                    addr_d  = pick1 ? r1_addr  : r0_addr;
                    wdata_d = pick1 ? r1_wdata : r0_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP) && !we_q;

    // Memory bus is driven only in ACCESS so it is quiet (all zero) otherwise.
    assign mem_en    = in_access;
    assign mem_we    = in_access && we_q;
    assign mem_addr  = in_access ? addr_q  : '0;
    assign mem_wdata = in_access ? wdata_q : '0;

    assign r0_gnt    = in_access && !win_q;
    assign r1_gnt    = in_access &&  win_q;
    assign r0_rvalid = in_resp && !win_q;
    assign r1_rvalid = in_resp &&  win_q;
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural data memory behind it.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] memArray [0:63];
   int          errorCount;
   int          checkCount;
   int          adjacentEn;
   logic        prevEn;

   dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Word-addressed memory with one-cycle registered read data.
   initial begin
      for (int i = 0; i < 64; i++) memArray[i] = 32'h0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         if (mem_en && mem_we) memArray[mem_addr[7:2]] = mem_wdata;
         if (mem_en && !mem_we) mem_rdata = memArray[mem_addr[7:2]];
      end
   end

   // Watches for mem_en high in two consecutive cycles.
   initial begin
      adjacentEn = 0;
      prevEn = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_en && prevEn) adjacentEn++;
         prevEn = mem_en;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic port, input logic req, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 1'b0) begin
         r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
      end else begin
         r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   int   grantSeen;
   logic expGrant [0:7];

   initial begin
      errorCount = 0;
      checkCount = 0;
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset held with a pending request: everything stays quiet.
      stepCycle();
      stepCycle();
      checkOutput("rst_r0_gnt", {31'd0, r0_gnt}, 32'd0);
      checkOutput("rst_r1_gnt", {31'd0, r1_gnt}, 32'd0);
      checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
      checkOutput("rst_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      reset = 1'b1;
      stepCycle();
      checkOutput("rel_r0_gnt", {31'd0, r0_gnt}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("rel_r0_rvalid", {31'd0, r0_rvalid}, 32'd1);
      checkOutput("rel_resp_mem_en", {31'd0, mem_en}, 32'd0);
      stepCycle();

      // Port 0 store of 25 to byte address 0x38.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h38, 32'd25);
      stepCycle();
      checkOutput("st_mem_en", {31'd0, mem_en}, 32'd1);
      checkOutput("st_mem_we", {31'd0, mem_we}, 32'd1);
      checkOutput("st_mem_addr", mem_addr, 32'h38);
      checkOutput("st_mem_wdata", mem_wdata, 32'd25);
      checkOutput("st_r0_gnt", {31'd0, r0_gnt}, 32'd1);
      checkOutput("st_r1_gnt", {31'd0, r1_gnt}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("st_idle_mem_en", {31'd0, mem_en}, 32'd0);
      checkOutput("st_idle_rvalid", {31'd0, r0_rvalid}, 32'd0);
      checkOutput("st_mem_word14", memArray[14], 32'd25);

      // Port 1 load of the word just stored.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h38, 32'h0);
      stepCycle();
      checkOutput("ld_r1_gnt", {31'd0, r1_gnt}, 32'd1);
      checkOutput("ld_r0_gnt", {31'd0, r0_gnt}, 32'd0);
      checkOutput("ld_mem_we", {31'd0, mem_we}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("ld_r1_rvalid", {31'd0, r1_rvalid}, 32'd1);
      checkOutput("ld_r1_rdata", r1_rdata, 32'd25);
      checkOutput("ld_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
      checkOutput("ld_r0_rdata", r0_rdata, 32'd0);
      stepCycle();

      // Both ports hold store requests; record the first eight grants.
`ifdef DMEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 8; i++) expGrant[i] = 1'b0;
`else
      for (int i = 0; i < 8; i++) expGrant[i] = i[0];
`endif
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 32'hA0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h20, 32'hB1);
      grantSeen = 0;
      for (int cyc = 0; cyc < 40 && grantSeen < 8; cyc++) begin
         stepCycle();
         if (r0_gnt || r1_gnt) begin
            checkOutput($sformatf("rr_grant%0d", grantSeen), {31'd0, r1_gnt}, {31'd0, expGrant[grantSeen]});
            grantSeen++;
         end
      end
      checkOutput("rr_grant_count", grantSeen, 32'd8);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();
      stepCycle();

      // Reset asserted during a load response drops the response.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h38, 32'h0);
      stepCycle();
      checkOutput("mid_r0_gnt", {31'd0, r0_gnt}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();
      reset = 1'b0;
      #1;
      checkOutput("mid_rvalid", {31'd0, r0_rvalid}, 32'd0);
      checkOutput("mid_mem_en", {31'd0, mem_en}, 32'd0);
      stepCycle();
      checkOutput("mid_hold_rvalid", {31'd0, r0_rvalid}, 32'd0);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h38, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h38, 32'h0);
      stepCycle();
      checkOutput("post_rst_tie_r0", {31'd0, r0_gnt}, 32'd1);
      checkOutput("post_rst_tie_r1", {31'd0, r1_gnt}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();
      stepCycle();

      // Port 1 request raised while port 0's store is in ACCESS.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 32'h77);
      stepCycle();
      checkOutput("late_r0_gnt", {31'd0, r0_gnt}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      checkOutput("late_no_gnt_access", {31'd0, r1_gnt}, 32'd0);
      stepCycle();
      checkOutput("late_no_gnt_idle", {31'd0, r1_gnt}, 32'd0);
      checkOutput("late_idle_mem_en", {31'd0, mem_en}, 32'd0);
      stepCycle();
      checkOutput("late_r1_gnt", {31'd0, r1_gnt}, 32'd1);
      checkOutput("late_mem_addr", mem_addr, 32'h40);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("late_r1_rvalid", {31'd0, r1_rvalid}, 32'd1);
      checkOutput("late_r1_rdata", r1_rdata, 32'h77);
      stepCycle();

      checkOutput("no_adjacent_mem_en", adjacentEn, 32'd0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
